// File: rtl/mux_arb_m.sv
// Two-channel valid/ready front end that arbitrates into a WIDTH-bit 2:1 mux.
// Build option: define MUX_ARB_FIXED_PRIO_EN to make ties always grant A instead of round-robin.
module mux_arb_m #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b,
  output logic             sel_a,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic run_q;
  logic a_full, b_full;
  logic sel_q, sel_d;
  logic a_take, b_take;
  logic a_done, b_done;
  logic tie_a;

  // Ready is held low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end

  assign a_ready = run_q & ~a_full;
  assign b_ready = run_q & ~b_full;
  assign a_take  = a_valid & a_ready;
  assign b_take  = b_valid & b_ready;
  assign a_done  = (state_q == GRANT_A) & out_ready;
  assign b_done  = (state_q == GRANT_B) & out_ready;

  // A full slot never accepts, so capture and release cannot coincide.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
    end else begin
      if (a_take)      a_full <= 1'b1;
      else if (a_done) a_full <= 1'b0;
      if (b_take)      b_full <= 1'b1;
      else if (b_done) b_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_a <= '0;
      data_b <= '0;
    end else begin
      if (a_take) data_a <= a_data;
      if (b_take) data_b <= b_data;
    end
  end

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign tie_a = 1'b1;
`else
  logic last_a;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)       last_a <= 1'b0;
    else if (a_done) last_a <= 1'b1;
    else if (b_done) last_a <= 1'b0;
  end

  assign tie_a = ~last_a;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Decisions use the registered full flags; a word captured this edge is seen next cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (a_full && b_full) state_d = tie_a ? GRANT_A : GRANT_B;
        else if (a_full)      state_d = GRANT_A;
        else if (b_full)      state_d = GRANT_B;
      end
      GRANT_A: if (out_ready) state_d = b_full ? GRANT_B : IDLE;
      GRANT_B: if (out_ready) state_d = a_full ? GRANT_A : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == GRANT_A)      sel_d = 1'b1;
    else if (state_d == GRANT_B) sel_d = 1'b0;
  end

  assign sel_a     = sel_q;
  assign out_valid = (state_q != IDLE);

endmodule
